multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore control FSM that sequences a multicycle MIPS datapath: one shared memory, ALU reused for PC+4/branch target.
//  Walks each instruction through FETCH/DECODE/execute/writeback states, drives every datapath enable and mux select.
//  Sits beside the register file, ALU and memory; consumes opcode/funct of the instruction register and the ALU zero flag.
// PARAMETERS
//  ALU_SEL_W   5   width of ALU select bus (matches ALU select port)
//  OP_W        6   width of opcode and funct fields
// PORTS
//  clock        in   1          single system clock, all state updates on posedge
//  reset_n      in   1          synchronous, active-low reset
//  opcode       in   OP_W       instr[31:26] from instruction register
//  funct        in   OP_W       instr[5:0]
//  zero         in   1          ALU zero flag, same cycle
//  mem_ready    in   1          memory done; used only with MEM_WAIT_EN, ignored otherwise
//  ir_write     out  1          load instruction register
//  pc_en        out  1          PC register enable = pc_write | (branch & zero)
//  pc_src       out  2          00 ALUResult, 01 ALUOut (branch target), 10 jump target
//  adr_src      out  1          memory address: 0 PC, 1 ALUOut
//  mem_write    out  1          memory write enable
//  reg_write    out  1          register file WE3
//  reg_dst      out  1          A3 select: 1 instr[15:11], 0 instr[20:16]
//  link         out  1          jal: A3 forced to 5'b11111, WD3 = PC
//  mem_to_reg   out  1          WD3 select: 1 memory data, 0 ALUOut
//  alu_src_a    out  1          0 PC, 1 RD1
//  alu_src_b    out  2          00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2
//  alu_select   out  ALU_SEL_W  ALU operation code
//  retire       out  1          1-cycle pulse in final state of each instruction
//  illegal      out  1          1-cycle pulse in DECODE on unsupported opcode/funct
// BEHAVIOUR
//  - reset_n low at posedge: state<=FETCH; while reset_n low all outputs forced 0 (combinational gate), alu_select=ADD.
//  - Reset mid-instruction: abandons it, no partial write after the reset edge; first post-reset cycle is FETCH.
//  - Outputs are pure functions of state (plus funct for alu_select in ALU_EXEC, zero for pc_en).
//  - States/transitions:
//    FETCH: adr_src=0, ir_write=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=00, pc_write=1 -> DECODE
//    DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target to ALUOut); by opcode:
//      100011 lw / 101011 sw -> MEM_ADR; 000000 R -> ALU_EXEC; 001000 addi -> ADDI_EXEC;
//      000100 beq -> BRANCH; 000010 j -> JUMP; 000011 jal -> JAL; other -> FETCH with illegal=1
//    MEM_ADR: alu_src_a=1, alu_src_b=10, ADD -> MEM_RD (lw) / MEM_WR (sw)
//    MEM_RD: adr_src=1 -> MEM_WB;  MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire -> FETCH
//    MEM_WR: adr_src=1, mem_write=1, retire -> FETCH
//    ALU_EXEC: alu_src_a=1, alu_src_b=00, alu_select from funct -> ALU_WB
//      funct 100000 ADD(2), 100010 SUB(6), 100100 AND(0), 100101 OR(1), 101010 SLT(7); other: illegal, treated as ADD
//    ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire -> FETCH
//    ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD -> ADDI_WB;  ADDI_WB: reg_write=1, reg_dst=0, retire -> FETCH
//    BRANCH: alu_src_a=1, alu_src_b=00, SUB, branch=1, pc_src=01, retire -> FETCH
//    JUMP: pc_src=10, pc_write=1, retire -> FETCH
//    JAL: pc_src=10, pc_write=1, reg_write=1, link=1, retire -> FETCH (PC already +4 from FETCH)
//  - Latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, jal 3; illegal opcode 2.
//  - Unlisted outputs are 0 in each state; alu_select defaults to ADD.
// CONFIGURATION
//  MULTICYCLE_MEM_WAIT_EN defined: FETCH, MEM_RD, MEM_WR hold while mem_ready=0; ir_write, pc_write,
//    mem_write asserted only in the cycle mem_ready=1, then transition; retire on MEM_WR only then.
//  Undefined: mem_ready ignored, every memory state lasts exactly one cycle.
// STRUCTURE
//  Package mips_ctrl_pkg: state_t enum, opcode and funct localparams, ALU select codes, pc_src/alu_src_b encodings.
//  Sub-module alu_decoder: combinational (funct, force_add, force_sub) -> alu_select, illegal_funct.
// TESTING
//  - Reset: hold reset_n=0 3 cycles with opcode=lw -> all outputs 0; release -> FETCH, ir_write=1, pc_en=1.
//  - lw (100011): state sequence FETCH,DECODE,MEM_ADR,MEM_RD,MEM_WB; reg_write+mem_to_reg only in cycle 5.
//  - beq zero=1 -> pc_en=1, pc_src=01 in cycle 3; zero=0 -> pc_en=0; both retire after 3 cycles.
//  - R funct 101010 -> alu_select=7 in ALU_EXEC, reg_dst=1 write in ALU_WB; funct 111111 -> illegal pulse.
//  - jal -> cycle 3 pc_en=1, pc_src=10, reg_write=1, link=1; opcode 111111 -> illegal, back to FETCH in 2.
//  - MEM_WAIT_EN: mem_ready low 4 cycles in FETCH -> no ir_write/pc_en until ready; reset mid-MEM_WR -> no mem_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct values,
// ALU select codes and datapath mux encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StAluExec,
        StAluWb,
        StAddiExec,
        StAddiWb,
        StBranch,
        StJump,
        StJal
    } state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [4:0] AluAnd = 5'd0;
    localparam logic [4:0] AluOr  = 5'd1;
    localparam logic [4:0] AluAdd = 5'd2;
    localparam logic [4:0] AluSub = 5'd6;
    localparam logic [4:0] AluSlt = 5'd7;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] SrcBRd2    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    function automatic logic is_supported_op(logic [5:0] op);
        return op inside {OpRtype, OpLw, OpSw, OpAddi, OpBeq, OpJ, OpJal};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU select decoder: maps R-type funct to an ALU operation, with overrides
// forcing ADD or SUB for the non-R-type states.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_SEL_W = 5,
    parameter int unsigned OP_W      = 6
) (
    input  logic [OP_W-1:0]      funct,
    input  logic                 force_add,
    input  logic                 force_sub,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 illegal_funct
);

    logic [4:0] funct_sel;

    always_comb begin
        funct_sel     = AluAdd;
        illegal_funct = 1'b0;
        case (funct)
            OP_W'(FnAdd): funct_sel = AluAdd;
            OP_W'(FnSub): funct_sel = AluSub;
            OP_W'(FnAnd): funct_sel = AluAnd;
            OP_W'(FnOr):  funct_sel = AluOr;
            OP_W'(FnSlt): funct_sel = AluSlt;
            default:      illegal_funct = 1'b1;
        endcase
    end

    always_comb begin
        if (force_sub) begin
            alu_select = ALU_SEL_W'(AluSub);
        end else if (force_add) begin
            alu_select = ALU_SEL_W'(AluAdd);
        end else begin
            alu_select = ALU_SEL_W'(funct_sel);
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath. Define MULTICYCLE_MEM_WAIT_EN to make the
// memory states (FETCH, MEM_RD, MEM_WR) stall until mem_ready.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_SEL_W = 5,
    parameter int unsigned OP_W      = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_src,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 link,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 retire,
    output logic                 illegal
);

    state_t state_q, state_d;
    logic   mem_ok;
    logic   pc_write, branch, force_add, force_sub, illegal_funct;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (mem_ok) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_W'(OpLw), OP_W'(OpSw): state_d = StMemAdr;
                    OP_W'(OpRtype):           state_d = StAluExec;
                    OP_W'(OpAddi):            state_d = StAddiExec;
                    OP_W'(OpBeq):             state_d = StBranch;
                    OP_W'(OpJ):               state_d = StJump;
                    OP_W'(OpJal):             state_d = StJal;
                    default:                  state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode == OP_W'(OpLw)) ? StMemRd : StMemWr;
            StMemRd:    if (mem_ok) state_d = StMemWb;
            StMemWr:    if (mem_ok) state_d = StFetch;
            StAluExec:  state_d = StAluWb;
            StAddiExec: state_d = StAddiWb;
            StMemWb, StAluWb, StAddiWb, StBranch, StJump, StJal: state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PcSrcAlu;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        link       = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBRd2;
        force_add  = 1'b1;
        force_sub  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            StFetch: begin
                alu_src_b = SrcBFour;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;
                // Bad R-type funct is flagged here but still executes as ADD.
                illegal   = !is_supported_op(opcode) ||
                            (opcode == OP_W'(OpRtype) && illegal_funct);
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRd: adr_src = 1'b1;
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StMemWr: begin
                adr_src   = 1'b1;
                mem_write = mem_ok;
                retire    = mem_ok;
            end
            StAluExec: begin
                alu_src_a = 1'b1;
                force_add = 1'b0;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                force_sub = 1'b1;
                branch    = 1'b1;
                pc_src    = PcSrcAluOut;
                retire    = 1'b1;
            end
            StJump: begin
                pc_src   = PcSrcJump;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            StJal: begin
                pc_src    = PcSrcJump;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                link      = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
        // Reset gates every output so a half-finished instruction cannot write anything.
        if (!reset_n) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            pc_src     = PcSrcAlu;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            link       = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SrcBRd2;
            force_add  = 1'b1;
            force_sub  = 1'b0;
            retire     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign pc_en = pc_write | (branch & zero);

    alu_decoder #(
        .ALU_SEL_W(ALU_SEL_W),
        .OP_W     (OP_W)
    ) u_alu_decoder (
        .funct        (funct),
        .force_add    (force_add),
        .force_sub    (force_sub),
        .alu_select   (alu_select),
        .illegal_funct(illegal_funct)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle tables are queued by the
// stimulus and compared against the DUT outputs by an independent monitor.
module tb_multicycle_controller;

    typedef struct packed {
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       link;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_select;
        logic       retire;
        logic       illegal;
    } out_t;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WaitEn = 1'b1;
`else
    localparam bit WaitEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       ir_write, pc_en, adr_src, mem_write, reg_write, reg_dst, link;
    logic       mem_to_reg, alu_src_a, retire, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [4:0] alu_select;

    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    int   exp_retire = 0;
    int   seen_retire = 0;
    out_t exp_q[$];
    out_t plan_o[$];
    logic plan_r[$];

    always #5 clock = ~clock;

    multicycle_controller #(
        .ALU_SEL_W(5),
        .OP_W     (6)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ir_write  (ir_write),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .adr_src   (adr_src),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .link      (link),
        .mem_to_reg(mem_to_reg),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_select(alu_select),
        .retire    (retire),
        .illegal   (illegal)
    );

    // Reference model: per-instruction output tables built straight from the ISA rules.
    function automatic out_t base();
        out_t o = '0;
        o.alu_select = 5'd2;
        return o;
    endfunction

    function automatic bit op_ok(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010,
                          6'b000011};
    endfunction

    function automatic bit fn_ok(logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [4:0] alu_code(logic [5:0] fn);
        case (fn)
            6'b100010: return 5'd6;
            6'b100100: return 5'd0;
            6'b100101: return 5'd1;
            6'b101010: return 5'd7;
            default:   return 5'd2;
        endcase
    endfunction

    function automatic void add(out_t o, logic r);
        plan_o.push_back(o);
        plan_r.push_back(r);
    endfunction

    // A memory cycle: optional stall cycles (busy) then the completing cycle (done).
    function automatic void mem_phase(out_t busy, out_t done);
        if (WaitEn) begin
            int n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) add(busy, 1'b0);
            add(done, 1'b1);
        end else begin
            add(done, 1'($urandom));
        end
    endfunction

    function automatic void build(logic [5:0] op, logic [5:0] fn, logic z);
        out_t o, busy;
        o = base();
        o.alu_src_b = 2'b01;
        busy = o;
        o.ir_write = 1'b1;
        o.pc_en = 1'b1;
        mem_phase(busy, o);
        o = base();
        o.alu_src_b = 2'b11;
        o.illegal = !op_ok(op) || (op == 6'b000000 && !fn_ok(fn));
        add(o, 1'($urandom));
        o = base();
        case (op)
            6'b100011, 6'b101011: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                add(o, 1'($urandom));
                o = base();
                o.adr_src = 1'b1;
                if (op == 6'b100011) begin
                    mem_phase(o, o);
                    o = base();
                    o.reg_write = 1'b1;
                    o.mem_to_reg = 1'b1;
                    o.retire = 1'b1;
                    add(o, 1'($urandom));
                end else begin
                    busy = o;
                    o.mem_write = 1'b1;
                    o.retire = 1'b1;
                    mem_phase(busy, o);
                end
            end
            6'b000000: begin
                o.alu_src_a = 1'b1;
                o.alu_select = alu_code(fn);
                add(o, 1'($urandom));
                o = base();
                o.reg_write = 1'b1;
                o.reg_dst = 1'b1;
                o.retire = 1'b1;
                add(o, 1'($urandom));
            end
            6'b001000: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                add(o, 1'($urandom));
                o = base();
                o.reg_write = 1'b1;
                o.retire = 1'b1;
                add(o, 1'($urandom));
            end
            6'b000100: begin
                o.alu_src_a = 1'b1;
                o.alu_select = 5'd6;
                o.pc_src = 2'b01;
                o.pc_en = z;
                o.retire = 1'b1;
                add(o, 1'($urandom));
            end
            6'b000010, 6'b000011: begin
                o.pc_src = 2'b10;
                o.pc_en = 1'b1;
                o.retire = 1'b1;
                o.reg_write = (op == 6'b000011);
                o.link = (op == 6'b000011);
                add(o, 1'($urandom));
            end
            default: ;
        endcase
    endfunction

    task automatic step(input out_t e, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int abort_at);
        plan_o.delete();
        plan_r.delete();
        opcode = op;
        funct = fn;
        zero = z;
        build(op, fn, z);
        for (int i = 0; i < plan_o.size(); i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                step(base(), 1'b1);
                reset_n = 1'b1;
                break;
            end
            if (plan_o[i].retire) exp_retire++;
            step(plan_o[i], plan_r[i]);
        end
    endtask

    initial begin : monitor
        out_t got, e;
        forever begin
            @(negedge clock);
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{ir_write, pc_en, pc_src, adr_src, mem_write, reg_write, reg_dst, link,
                        mem_to_reg, alu_src_a, alu_src_b, alu_select, retire, illegal};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d op=%b fn=%b: got %h required %h",
                             cycle_no, opcode, funct, got, e);
                end
                if (reset_n && retire === 1'b1) seen_retire++;
            end
        end
    end

    initial begin : stimulus
        logic [5:0] op, fn;
        logic [5:0] legal_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100,
                                     6'b000010, 6'b000011};
        logic [5:0] legal_fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        int abort_at;
        reset_n = 1'b0;
        opcode = 6'b100011;
        funct = 6'b100000;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step(base(), 1'($urandom));
        reset_n = 1'b1;

        run(6'b100011, 6'b000000, 1'b0, -1);
        run(6'b000100, 6'b000000, 1'b1, -1);
        run(6'b000100, 6'b000000, 1'b0, -1);
        run(6'b000000, 6'b101010, 1'b0, -1);
        run(6'b000000, 6'b111111, 1'b0, -1);
        run(6'b000011, 6'b000000, 1'b1, -1);
        run(6'b111111, 6'b000000, 1'b0, -1);
        run(6'b101011, 6'b100000, 1'b0, -1);
        run(6'b001000, 6'b000000, 1'b0, -1);
        run(6'b000010, 6'b000000, 1'b0, -1);
        // Reset landing on the final sw cycle must suppress mem_write.
        plan_o.delete();
        plan_r.delete();
        build(6'b101011, 6'b0, 1'b0);
        run(6'b101011, 6'b000000, 1'b0, plan_o.size() + 100);
        run(6'b101011, 6'b000000, 1'b0, 3);
        run(6'b100011, 6'b000000, 1'b0, 2);

        for (int n = 0; n < 80; n++) begin
            int k = $urandom_range(0, 8);
            if (k < 7) begin
                op = legal_ops[k];
            end else if (k == 7) begin
                op = 6'b111111;
            end else begin
                do op = 6'($urandom); while (op_ok(op));
            end
            k = $urandom_range(0, 5);
            fn = (k < 5) ? legal_fns[k] : 6'($urandom);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run(op, fn, 1'($urandom), abort_at);
        end

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        checks++;
        if (seen_retire != exp_retire) begin
            errors++;
            $display("FAIL retire_count: got %0d required %0d", seen_retire, exp_retire);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
